// File: rtl/ram_loader_if.sv
// Byte stream in, RAM port A write out. The loader takes the master side and the
// stream source / RAM take the slave side.
interface ram_loader_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32
);
  logic [7:0]        s_data;
  logic              s_valid;
  logic              s_ready;
  logic              wea;
  logic [ADDR_W-1:0] addra;
  logic [DATA_W-1:0] dina;

  modport master (input s_data, s_valid, output s_ready, wea, addra, dina);
  modport slave  (output s_data, s_valid, input s_ready, wea, addra, dina);
endinterface

// File: rtl/ram_loader.sv
// Program loader: packs stream bytes little-endian into RAM words and holds the CPU in reset
// until the requested number of words has been written.
//  state | meaning
//  IDLE  | after reset, waiting for start, cpu held in reset
//  RECV  | collecting bytes of the current word
//  WRITE | one-cycle RAM write of the packed word
//  DONE  | load finished, cpu released, waiting for a new start
module ram_loader #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   len,
  ram_loader_if.master      bus,
  output logic              busy,
  output logic              done,
  output logic              cpu_rst,
  output logic [7:0]        chk
);
  localparam int BPW  = DATA_W / 8;
  localparam int BC_W = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [ADDR_W:0] MAXLEN = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [BC_W-1:0] LASTB  = BC_W'(BPW - 1);

  typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

  state_t            state, state_n;
  logic [ADDR_W:0]   len_q, len_n, wcnt, wcnt_n;
  logic [ADDR_W-1:0] widx, widx_n, addra_q, addra_n;
  logic [BC_W-1:0]   bcnt, bcnt_n;
  logic [DATA_W-1:0] word, word_n, dina_q, dina_n;
  logic [7:0]        chk_n;
  logic              s_ready_q, s_ready_n, wea_q, wea_n;
  logic              busy_n, done_n, cpu_rst_n;

  assign bus.s_ready = s_ready_q;
  assign bus.wea     = wea_q;
  assign bus.addra   = addra_q;
  assign bus.dina    = dina_q;

  // Outputs are computed alongside the next state and registered with it.
  always_comb begin
    state_n   = state;
    len_n     = len_q;
    wcnt_n    = wcnt;
    widx_n    = widx;
    bcnt_n    = bcnt;
    word_n    = word;
    chk_n     = chk;
    addra_n   = addra_q;
    dina_n    = dina_q;
    s_ready_n = s_ready_q;
    wea_n     = 1'b0;
    busy_n    = busy;
    done_n    = done;
    cpu_rst_n = cpu_rst;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          len_n     = (len > MAXLEN) ? MAXLEN : len;
          wcnt_n    = '0;
          widx_n    = '0;
          bcnt_n    = '0;
          chk_n     = '0;
          if (len == '0) begin
            state_n   = DONE;
            done_n    = 1'b1;
            cpu_rst_n = 1'b0;
          end else begin
            state_n   = RECV;
            done_n    = 1'b0;
            busy_n    = 1'b1;
            s_ready_n = 1'b1;
            cpu_rst_n = 1'b1;
          end
        end
      end
      RECV: begin
        if (bus.s_valid && s_ready_q) begin
          for (int k = 0; k < BPW; k++)
            if (bcnt == BC_W'(k)) word_n[8*k +: 8] = bus.s_data;
          chk_n  = chk ^ bus.s_data;
          bcnt_n = bcnt + 1'b1;
          if (bcnt == LASTB) begin
            bcnt_n    = '0;
            state_n   = WRITE;
            s_ready_n = 1'b0;
            wea_n     = 1'b1;
            addra_n   = widx;
            dina_n    = word_n;
          end
        end
      end
      WRITE: begin
        widx_n = widx + 1'b1;
        wcnt_n = wcnt + 1'b1;
        if (wcnt_n == len_q) begin
          state_n   = DONE;
          busy_n    = 1'b0;
          done_n    = 1'b1;
          cpu_rst_n = 1'b0;
        end else begin
          state_n   = RECV;
          s_ready_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      len_q     <= '0;
      wcnt      <= '0;
      widx      <= '0;
      bcnt      <= '0;
      word      <= '0;
      chk       <= '0;
      addra_q   <= '0;
      dina_q    <= '0;
      s_ready_q <= 1'b0;
      wea_q     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cpu_rst   <= 1'b1;
    end else begin
      state     <= state_n;
      len_q     <= len_n;
      wcnt      <= wcnt_n;
      widx      <= widx_n;
      bcnt      <= bcnt_n;
      word      <= word_n;
      chk       <= chk_n;
      addra_q   <= addra_n;
      dina_q    <= dina_n;
      s_ready_q <= s_ready_n;
      wea_q     <= wea_n;
      busy      <= busy_n;
      done      <= done_n;
      cpu_rst   <= cpu_rst_n;
    end
  end
endmodule
